mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, RAM/core address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum busy cycles before error.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 imem_req  in  1  core requests an instruction fetch (level).
REQ-007 imemaddr  in  ADDR_W  fetch address (the PC).
REQ-008 dmem_ren / dmem_wen  in  1 each  core data read / write request (level).
REQ-009 dmmaddr  in  ADDR_W  data address (ALU result).
REQ-010 dmmstore  in  DATA_W  store data.
REQ-011 imemload / dmmload  out  DATA_W each  registered fetched instruction / loaded data.
REQ-012 i_ready / d_ready  out  1 each  one-cycle completion pulses.
REQ-013 ramaddr  out  ADDR_W, ramstore  out  DATA_W, ram_ren / ram_wen  out  1 each  RAM-side request.
REQ-014 ramload  in  DATA_W, busy_o  in  1  RAM read data and busy.
REQ-015 err_o  out  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT.
REQ-017 IDLE: data request pending and dserved==0 -> D_REQ; else imem_req -> I_REQ; else stay.
REQ-018 Data SHALL have priority over fetch when both are asserted in the same IDLE cycle.
REQ-019 dmem_wen and dmem_ren both high SHALL be treated as a write; ren ignored.
REQ-020 On leaving IDLE, address, store data, and type SHALL be latched; the core may change inputs afterwards without effect.
REQ-021 I_REQ/D_REQ: ram_ren (or ram_wen) high for exactly that one cycle with the latched address; next state is the matching WAIT.
REQ-022 ramaddr SHALL be the latched address with bits [1:0] forced to 0; ramaddr/ramstore held stable in REQ and WAIT.
REQ-023 WAIT: first cycle with busy_o==0 captures ramload (reads only), returns to IDLE; ready pulses on the following cycle.
REQ-024 Zero-wait RAM: request seen in IDLE at cycle 0 -> ready high at cycle 3.
REQ-025 dserved SHALL set on d_ready and clear on i_ready, so a held data request is served once per instruction.
REQ-026 Writes SHALL pulse d_ready and leave dmmload unchanged.
REQ-027 Request deasserted during REQ/WAIT SHALL NOT abort; transaction completes and ready still pulses.
REQ-028 Busy counter SHALL count WAIT cycles with busy_o==1; on reaching TIMEOUT, set err_o, abort to IDLE, and pulse no ready.
REQ-029 ram_ren/ram_wen SHALL be 0 in IDLE and WAIT states.

Reset
REQ-030 nrst low SHALL immediately force IDLE, including mid-transaction.
REQ-031 nrst low SHALL immediately zero all outputs, dserved, the counter, and err_o.
REQ-032 No ready pulse SHALL occur for a transaction interrupted by reset.

Structure
REQ-033 Package mem_req_pkg SHALL hold the state enum and the ADDR_W/DATA_W/TIMEOUT defaults.
REQ-034 Sub-module mem_watchdog SHALL implement the busy counter and err_o.

Verification
REQ-035 Fetch, busy_o=0: imem_req, imemaddr=0x10, ramload=0x00A00093 -> ram_ren pulse with ramaddr=0x10; i_ready at cycle 3; imemload=0x00A00093.
REQ-036 Simultaneous: imem_req and dmem_ren (dmmaddr=0x24) in IDLE -> data served first (d_ready), then fetch (i_ready); no second data access until after i_ready.
REQ-037 Store, busy_o high 4 cycles: dmem_wen, dmmaddr=0x27, dmmstore=0xDEADBEEF -> ramaddr=0x24, ram_wen one cycle, d_ready 1 cycle after busy_o falls, dmmload unchanged.
REQ-038 Timeout: busy_o stuck high -> err_o set after 255 busy cycles, FSM IDLE, no ready; err_o stays high until reset.
REQ-039 Reset during I_WAIT -> outputs 0 asynchronously, no i_ready after release, next imem_req served normally.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and default sizing for the memory request unit.
package mem_req_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      IDLE,
      I_REQ,
      I_WAIT,
      D_REQ,
      D_WAIT
   } state_t;

endpackage

// File: rtl/mem_request_unit_if.sv
// RAM-side bus of the memory request unit.
// ram_ren/ram_wen are single-cycle strobes carrying ramaddr/ramstore; the RAM holds
// busy_o high while working, and ramload is taken in the first later cycle with busy_o low.
interface mem_request_unit_if
   import mem_req_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic              ram_ren;
   logic              ram_wen;
   logic [DATA_W-1:0] ramload;
   logic              busy_o;

   modport master (
      output ramaddr, ramstore, ram_ren, ram_wen,
      input  ramload, busy_o
   );

   modport slave (
      input  ramaddr, ramstore, ram_ren, ram_wen,
      output ramload, busy_o
   );

endinterface

// File: rtl/mem_watchdog.sv
// Counts busy cycles while waiting on the RAM; flags a timeout and holds a sticky error.
module mem_watchdog
   import mem_req_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic nrst,
   input  logic waiting,
   input  logic busy,
   output logic timeout,
   output logic err_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Fires during the TIMEOUT-th busy cycle so the FSM can leave on that same edge.
   assign timeout = waiting && busy && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt   <= '0;
         err_o <= 1'b0;
      end else begin
         if (!waiting || timeout) begin
            cnt <= '0;
         end else if (busy) begin
            cnt <= cnt + CW'(1);
         end
         if (timeout) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_request_unit.sv
// Arbitrates core fetch and data requests onto a single-port RAM, one transaction at a time.
module mem_request_unit
   import mem_req_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                imem_req,
   input  logic [ADDR_W-1:0]   imemaddr,
   input  logic                dmem_ren,
   input  logic                dmem_wen,
   input  logic [ADDR_W-1:0]   dmmaddr,
   input  logic [DATA_W-1:0]   dmmstore,
   output logic [DATA_W-1:0]   imemload,
   output logic [DATA_W-1:0]   dmmload,
   output logic                i_ready,
   output logic                d_ready,
   output logic                err_o,
   output state_t              state,
   mem_request_unit_if.master  ram
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic              lat_write;
   logic              dserved;
   logic              d_pending, waiting, timeout, done_i, done_d;

   // dserved blocks a held data request from being replayed before the next fetch.
   assign d_pending = (dmem_ren || dmem_wen) && !dserved;
   assign waiting   = (state_q == I_WAIT) || (state_q == D_WAIT);
   assign done_i    = (state_q == I_WAIT) && !ram.busy_o;
   assign done_d    = (state_q == D_WAIT) && !ram.busy_o;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (d_pending)     state_d = D_REQ;
            else if (imem_req) state_d = I_REQ;
         end
         I_REQ:  state_d = I_WAIT;
         D_REQ:  state_d = D_WAIT;
         I_WAIT, D_WAIT: begin
            if (timeout || !ram.busy_o) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
         imemload  <= '0;
         dmmload   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
         dserved   <= 1'b0;
      end else begin
         if (state_q == IDLE && d_pending) begin
            lat_addr  <= dmmaddr & ~ADDR_W'(3);
            lat_data  <= dmmstore;
            lat_write <= dmem_wen;
         end else if (state_q == IDLE && imem_req) begin
            lat_addr  <= imemaddr & ~ADDR_W'(3);
            lat_write <= 1'b0;
         end
         i_ready <= done_i;
         d_ready <= done_d;
         if (done_i) imemload <= ram.ramload;
         if (done_d && !lat_write) dmmload <= ram.ramload;
         if (done_d)      dserved <= 1'b1;
         else if (done_i) dserved <= 1'b0;
      end
   end

   assign ram.ramaddr  = lat_addr;
   assign ram.ramstore = lat_data;
   assign ram.ram_ren  = (state_q == I_REQ) || ((state_q == D_REQ) && !lat_write);
   assign ram.ram_wen  = (state_q == D_REQ) && lat_write;
   assign state        = state_q;

   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .nrst    (nrst),
      .waiting (waiting),
      .busy    (ram.busy_o),
      .timeout (timeout),
      .err_o   (err_o)
   );

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit with a transaction-level reference model.
module tb_mem_request_unit;
   import mem_req_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 255;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic          imem_req, dmem_ren, dmem_wen;
   logic [AW-1:0] imemaddr, dmmaddr;
   logic [DW-1:0] dmmstore, imemload, dmmload;
   logic          i_ready, d_ready, err_o;
   state_t        state;

   mem_request_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

   mem_request_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .imem_req (imem_req),
      .imemaddr (imemaddr),
      .dmem_ren (dmem_ren),
      .dmem_wen (dmem_wen),
      .dmmaddr  (dmmaddr),
      .dmmstore (dmmstore),
      .imemload (imemload),
      .dmmload  (dmmload),
      .i_ready  (i_ready),
      .d_ready  (d_ready),
      .err_o    (err_o),
      .state    (state),
      .ram      (ram_if.master)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_active, m_fetch, m_write, m_dserved, m_iready, m_dready, m_err;
   int          m_phase, m_busycnt;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data, m_imemload, m_dmmload;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_active = 0; m_fetch = 0; m_write = 0; m_dserved = 0;
         m_iready = 0; m_dready = 0; m_err = 0;
         m_phase = 0; m_busycnt = 0;
         m_addr = '0; m_data = '0; m_imemload = '0; m_dmmload = '0;
      end else begin
         m_iready = 0;
         m_dready = 0;
         if (!m_active) begin
            if ((dmem_ren || dmem_wen) && !m_dserved) begin
               m_active = 1; m_fetch = 0; m_write = dmem_wen;
               m_addr = {dmmaddr[AW-1:2], 2'b00};
               m_data = dmmstore;
               m_phase = 0; m_busycnt = 0;
            end else if (imem_req) begin
               m_active = 1; m_fetch = 1; m_write = 0;
               m_addr = {imemaddr[AW-1:2], 2'b00};
               m_phase = 0; m_busycnt = 0;
            end
         end else if (m_phase == 0) begin
            m_phase = 1;
         end else if (!ram_if.busy_o) begin
            m_active = 0;
            if (m_fetch) begin
               m_iready = 1; m_imemload = ram_if.ramload; m_dserved = 0;
            end else begin
               m_dready = 1; m_dserved = 1;
               if (!m_write) m_dmmload = ram_if.ramload;
            end
         end else begin
            m_busycnt++;
            if (m_busycnt == TO) begin
               m_err = 1;
               m_active = 0;
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      chk("i_ready", i_ready, m_iready);
      chk("d_ready", d_ready, m_dready);
      chk("imemload", imemload, m_imemload);
      chk("dmmload", dmmload, m_dmmload);
      chk("err_o", err_o, m_err);
      chk("ram_ren", ram_if.ram_ren, m_active && m_phase == 0 && !m_write);
      chk("ram_wen", ram_if.ram_wen, m_active && m_phase == 0 && m_write);
      chk("idle", state == IDLE, !m_active);
      if (m_active) chk("ramaddr", ram_if.ramaddr, m_addr);
      if (m_active && m_write) chk("ramstore", ram_if.ramstore, m_data);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_once(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] ld);
      int i_at;
      i_at = -1;
      imemaddr = a;
      ram_if.ramload = ld;
      imem_req = 1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            chk({tag, "_ram_ren"}, ram_if.ram_ren, 1'b1);
            chk({tag, "_ramaddr"}, ram_if.ramaddr, a);
            imem_req = 0;
            imemaddr = 32'hFFFF_FFF0;
         end
         if (i_ready && i_at < 0) i_at = k;
      end
      chk({tag, "_i_ready_cycle"}, i_at, 3);
      chk({tag, "_imemload"}, imemload, ld);
   endtask

   initial begin
      int d_at, i_at, r_cnt, w_cnt, err_at, rdy_cnt;
      imem_req = 0; dmem_ren = 0; dmem_wen = 0;
      imemaddr = '0; dmmaddr = '0; dmmstore = '0;
      ram_if.ramload = '0; ram_if.busy_o = 0;

      #12;
      chk("rst_i_ready", i_ready, 1'b0);
      chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_ram_ren", ram_if.ram_ren, 1'b0);
      chk("rst_ramaddr", ram_if.ramaddr, 32'h0);
      chk("rst_imemload", imemload, 32'h0);
      chk("rst_state", state == IDLE, 1'b1);
      tick();
      nrst = 1;
      tick();

      // zero-wait fetch
      fetch_once("t1", 32'h10, 32'h00A0_0093);

      // simultaneous data read + fetch: data wins, fetch next
      dmmaddr = 32'h24; imemaddr = 32'h20; ram_if.ramload = 32'h1122_3344;
      imem_req = 1; dmem_ren = 1;
      d_at = -1; i_at = -1; r_cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (ram_if.ram_ren) r_cnt++;
         if (d_ready && d_at < 0) d_at = k;
         if (d_ready) ram_if.ramload = 32'h0000_0013;
         if (i_ready && i_at < 0) i_at = k;
         if (k == 6) begin imem_req = 0; dmem_ren = 0; end
      end
      chk("t2_d_ready_cycle", d_at, 3);
      chk("t2_i_ready_cycle", i_at, 6);
      chk("t2_ren_count", r_cnt, 2);
      chk("t2_dmmload", dmmload, 32'h1122_3344);
      chk("t2_imemload", imemload, 32'h0000_0013);

      // store with 4 busy cycles, unaligned address
      ram_if.ramload = 32'hBAD0_BAD0; ram_if.busy_o = 1;
      dmem_wen = 1; dmmaddr = 32'h27; dmmstore = 32'hDEAD_BEEF;
      d_at = -1; w_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            chk("t3_ram_wen", ram_if.ram_wen, 1'b1);
            chk("t3_ramaddr", ram_if.ramaddr, 32'h24);
            chk("t3_ramstore", ram_if.ramstore, 32'hDEAD_BEEF);
            dmem_wen = 0; dmmaddr = '0; dmmstore = '0;
         end
         if (ram_if.ram_wen) w_cnt++;
         if (k == 6) ram_if.busy_o = 0;
         if (d_ready && d_at < 0) d_at = k;
      end
      chk("t3_d_ready_cycle", d_at, 7);
      chk("t3_wen_count", w_cnt, 1);
      chk("t3_dmmload_kept", dmmload, 32'h1122_3344);

      // ren+wen with fetch while data already served: fetch first, then a write
      imemaddr = 32'h30; ram_if.ramload = 32'h0000_0093;
      dmmaddr = 32'h48; dmmstore = 32'hCAFE_F00D;
      imem_req = 1; dmem_ren = 1; dmem_wen = 1;
      d_at = -1; i_at = -1; r_cnt = 0; w_cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (ram_if.ram_ren) r_cnt++;
         if (ram_if.ram_wen) w_cnt++;
         if (i_ready && i_at < 0) i_at = k;
         if (d_ready && d_at < 0) d_at = k;
         if (k == 4) begin imem_req = 0; dmem_ren = 0; dmem_wen = 0; end
      end
      chk("t4_i_ready_cycle", i_at, 3);
      chk("t4_d_ready_cycle", d_at, 6);
      chk("t4_ren_count", r_cnt, 1);
      chk("t4_wen_count", w_cnt, 1);
      chk("t4_dmmload_kept", dmmload, 32'h1122_3344);

      // timeout: busy stuck high
      ram_if.busy_o = 1; imemaddr = 32'h50; imem_req = 1;
      err_at = -1; rdy_cnt = 0;
      for (int k = 1; k <= 270; k++) begin
         tick();
         if (k == 1) imem_req = 0;
         if (i_ready || d_ready) rdy_cnt++;
         if (err_o && err_at < 0) err_at = k;
      end
      chk("t5_err_cycle", err_at, 257);
      chk("t5_no_ready", rdy_cnt, 0);
      chk("t5_state_idle", state == IDLE, 1'b1);
      ram_if.busy_o = 0;
      for (int k = 0; k < 5; k++) tick();
      chk("t5_err_sticky", err_o, 1'b1);

      // asynchronous reset in I_WAIT
      ram_if.busy_o = 1; imemaddr = 32'h60; ram_if.ramload = 32'h7777_7777;
      imem_req = 1;
      tick();
      imem_req = 0;
      tick();
      #2 nrst = 0;
      #1;
      chk("t6_err", err_o, 1'b0);
      chk("t6_imemload", imemload, 32'h0);
      chk("t6_dmmload", dmmload, 32'h0);
      chk("t6_ramaddr", ram_if.ramaddr, 32'h0);
      chk("t6_ram_ren", ram_if.ram_ren, 1'b0);
      chk("t6_state", state == IDLE, 1'b1);
      ram_if.busy_o = 0;
      tick();
      tick();
      nrst = 1;
      rdy_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (i_ready) rdy_cnt++;
      end
      chk("t6_no_i_ready", rdy_cnt, 0);

      // fetch after reset recovers
      fetch_once("t7", 32'h40, 32'h1234_5678);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
